div_share_ctrl: RTL and testbench
=================================

Name: div_share_ctrl

Overview:
Sequencing and arbitration controller that shares one iterative restoring divider between two requesters. Each requester presents a dividend/divisor pair on a valid/ready handshake. A round-robin arbiter grants one request at a time. The controller runs WIDTH shift-subtract iterations and returns quotient, remainder, requester ID and a divide-by-zero flag on a valid/ready response channel.

Parameters:
WIDTH, 4, operand/result bit width (dividend, divisor, quotient, remainder)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
ena  input  1  global enable; low freezes all state
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 accepted this cycle when valid&ready
req0_dividend  input  WIDTH  requester 0 dividend
req0_divisor  input  WIDTH  requester 0 divisor
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 accept strobe (as above)
req1_dividend  input  WIDTH  requester 1 dividend
req1_divisor  input  WIDTH  requester 1 divisor
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_id  output  1  requester that issued the result
rsp_quotient  output  WIDTH  quotient
rsp_remainder  output  WIDTH  remainder
rsp_dbz  output  1  divisor was zero
busy  output  1  state != IDLE
stat_ops  output  16  completed-op count (see Optional Feature)
stat_dbz  output  16  divide-by-zero count (see Optional Feature)

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; priority pointer=0.
  - rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, busy = 0.
  - stat counters = 0.
- States and transitions:
  - IDLE: on grant → CALC, or → DONE if divisor==0.
  - CALC: counts WIDTH iterations, then → DONE.
  - DONE: on rsp_valid & rsp_ready → IDLE.
- Grant:
  - Computed combinationally: reqN_ready = (state==IDLE) & ena & grantN.
  - A single valid requester always wins.
  - When both are valid, the pointer's requester wins.
  - After each acceptance the pointer becomes the non-accepted index.
  - Ready depends on the other requester's valid; requesters must not make valid depend on ready.
- Acceptance edge E0 latches operands and ID.
  - Divisor==0: go straight to DONE with quotient and remainder all-ones and rsp_dbz=1. rsp_valid is visible in the cycle after E0.
  - Otherwise: CALC performs one iteration per enabled edge E1..EWIDTH. rsp_valid is visible after EWIDTH, i.e. latency WIDTH cycles from acceptance.
- Iteration (restoring):
  - Partial remainder is WIDTH+1 bits; t = {rem, dividend MSB shifted in}.
  - If t >= divisor: rem = t − divisor, quotient bit = 1; else rem = t, bit = 0.
  - The dividend shift register becomes the quotient.
- DONE:
  - All rsp_* outputs are stable while rsp_valid=1 and rsp_ready=0.
  - No new request is accepted until the response handshake completes; the earliest next acceptance is the cycle after the handshake.
- ena=0: no acceptance, no iteration, no state change, and rsp_ready is ignored. Outputs hold.
- rst mid-CALC or mid-DONE: the in-flight operation is discarded; no response is produced.

Optional Feature:
- Macro DIV_SHARE_STATS_EN.
- Defined:
  - stat_ops increments on each response handshake; stat_dbz increments on handshakes with rsp_dbz=1.
  - Both counters saturate at 16'hFFFF and are cleared by rst.
- Undefined: no counter logic; stat_ops and stat_dbz are tied to 0. Ports are present in both builds.

Decomposition:
- Shared package div_pkg:
  - state enum (IDLE, CALC, DONE)
  - default WIDTH
  - DBZ result constant (all-ones)
  - iteration counter width, $clog2(WIDTH+1)
- One sub-module, div_restore_step: combinational single iteration taking rem, shift-in bit and divisor, producing next rem and quotient bit. The controller instantiates it once.

Test Plan:
1. Only req0: 13/3 → accepted at E0; rsp_valid 4 cycles later with id=0, q=4, r=1, dbz=0.
2. Both valid after reset, req0 9/2 and req1 15/4 → req0 first (q=4, r=1, id=0), then req1 (q=3, r=3, id=1). A third simultaneous pair goes to req0.
3. req1 7/0 → rsp_valid in the cycle after acceptance with q=F, r=F, dbz=1, id=1. With the macro defined, stat_dbz=1 and stat_ops=1 after the handshake.
4. rsp_ready held low for 5 cycles in DONE → rsp fields constant, both req ready=0, busy=1; the handshake then returns to IDLE.
5. ena low for 3 cycles during CALC of 14/5 → rsp_valid delayed exactly 3 cycles; q=2, r=4.
6. rst pulsed during CALC → next cycle rsp_valid=0, busy=0, pointer=0; a fresh 8/8 completes with q=1, r=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the shared restoring-divider controller.
package div_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned CNT_W     = $clog2(DEF_WIDTH + 1);

    // Quotient/remainder reported for a zero divisor
    localparam logic [DEF_WIDTH-1:0] DBZ_RESULT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_share_if.sv
// Request/response bundle between two requesters, a consumer and the divider controller.
interface div_share_if import div_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_dividend;
    logic [WIDTH-1:0] req0_divisor;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_dividend;
    logic [WIDTH-1:0] req1_divisor;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_quotient;
    logic [WIDTH-1:0] rsp_remainder;
    logic             rsp_dbz;

    modport master (
        output req0_valid, req0_dividend, req0_divisor,
        output req1_valid, req1_dividend, req1_divisor,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_dividend, req0_divisor,
        input  req1_valid, req1_dividend, req1_divisor,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz,
        input  rsp_ready
    );
endinterface

// File: rtl/div_restore_step.sv
// One restoring shift-subtract iteration: shift a dividend bit into the partial remainder.
module div_restore_step import div_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic             shift_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);
    logic [WIDTH+1:0] trial;

    always_comb begin
        trial    = {rem, shift_in};
        q_bit    = (trial >= (WIDTH+2)'(divisor));
        rem_next = q_bit ? (WIDTH+1)'(trial - (WIDTH+2)'(divisor)) : (WIDTH+1)'(trial);
    end
endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin sharing of one iterative restoring divider between two requesters.
// Optional saturating op/dbz counters are built when DIV_SHARE_STATS_EN is defined.
module div_share_ctrl import div_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    div_share_if.slave  bus,
    output logic        busy,
    output logic [15:0] stat_ops,
    output logic [15:0] stat_dbz
);
    localparam int unsigned      CW        = CNT_W;
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] DBZ_VAL   = WIDTH'(DBZ_RESULT);

    state_t           state, state_d;
    logic             ptr;
    logic             op_id;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    cnt;
    logic             rsp_valid_q, rsp_id_q, rsp_dbz_q;
    logic [WIDTH-1:0] rsp_q_q, rsp_r_q;

    logic             rdy0_c, rdy1_c, accept_c, rsp_hs_c, last_c;
    logic [WIDTH-1:0] acc_dividend_c, acc_divisor_c;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;

    // Round-robin grant; the pointer only breaks ties
    always_comb begin
        rdy0_c = (state == IDLE) & ena & bus.req0_valid & (~bus.req1_valid | ~ptr);
        rdy1_c = (state == IDLE) & ena & bus.req1_valid & (~bus.req0_valid | ptr);
        accept_c       = rdy0_c | rdy1_c;
        acc_dividend_c = rdy1_c ? bus.req1_dividend : bus.req0_dividend;
        acc_divisor_c  = rdy1_c ? bus.req1_divisor  : bus.req0_divisor;
        rsp_hs_c       = ena & (state == DONE) & rsp_valid_q & bus.rsp_ready;
        last_c         = (cnt == LAST_ITER);
    end

    assign bus.req0_ready    = rdy0_c;
    assign bus.req1_ready    = rdy1_c;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_quotient  = rsp_q_q;
    assign bus.rsp_remainder = rsp_r_q;
    assign bus.rsp_dbz       = rsp_dbz_q;

    always_comb begin
        state_d = state;
        if (ena) begin
            case (state)
                IDLE:    if (accept_c) state_d = (acc_divisor_c == '0) ? DONE : CALC;
                CALC:    if (last_c)   state_d = DONE;
                DONE:    if (rsp_hs_c) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .shift_in (dvd[WIDTH-1]),
        .divisor  (dsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Operand capture, iteration datapath and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= 1'b0;
            op_id       <= 1'b0;
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_dbz_q   <= 1'b0;
            rsp_q_q     <= '0;
            rsp_r_q     <= '0;
        end else begin
            busy <= (state_d != IDLE);
            if (accept_c) begin
                ptr   <= ~rdy1_c;
                op_id <= rdy1_c;
                dvd   <= acc_dividend_c;
                dsr   <= acc_divisor_c;
                rem   <= '0;
                cnt   <= '0;
                if (acc_divisor_c == '0) begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= rdy1_c;
                    rsp_dbz_q   <= 1'b1;
                    rsp_q_q     <= DBZ_VAL;
                    rsp_r_q     <= DBZ_VAL;
                end
            end
            if (ena && (state == CALC)) begin
                dvd <= {dvd[WIDTH-2:0], q_bit};
                rem <= rem_next;
                cnt <= cnt + CW'(1);
                if (last_c) begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= op_id;
                    rsp_dbz_q   <= 1'b0;
                    rsp_q_q     <= {dvd[WIDTH-2:0], q_bit};
                    rsp_r_q     <= rem_next[WIDTH-1:0];
                end
            end
            if (rsp_hs_c) rsp_valid_q <= 1'b0;
        end
    end

`ifdef DIV_SHARE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops <= '0;
            stat_dbz <= '0;
        end else if (rsp_hs_c) begin
            if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
            if (rsp_dbz_q && (stat_dbz != 16'hFFFF)) stat_dbz <= stat_dbz + 16'd1;
        end
    end
`else
    assign stat_ops = '0;
    assign stat_dbz = '0;
`endif

endmodule

// File: tb/tb_div_share_ctrl.sv
// Self-checking bench for div_share_ctrl against an arithmetic reference model.
module tb_div_share_ctrl;
    localparam int unsigned W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        busy;
    logic [15:0] stat_ops;
    logic [15:0] stat_dbz;

    div_share_if #(.WIDTH(W)) bus ();

    div_share_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .bus      (bus),
        .busy     (busy),
        .stat_ops (stat_ops),
        .stat_dbz (stat_dbz)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit m_ptr;
    int m_ops;
    int m_dbz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats();
`ifdef DIV_SHARE_STATS_EN
        check("stat_ops", 32'(stat_ops), 32'(m_ops));
        check("stat_dbz", 32'(stat_dbz), 32'(m_dbz));
`else
        check("stat_ops", 32'(stat_ops), 32'(0));
        check("stat_dbz", 32'(stat_dbz), 32'(0));
`endif
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        step();
        step();
        rst   = 1'b0;
        m_ptr = 1'b0;
        m_ops = 0;
        m_dbz = 0;
        check("rst_valid", 32'(bus.rsp_valid), 32'(0));
        check("rst_busy",  32'(busy), 32'(0));
        check("rst_q",     32'(bus.rsp_quotient), 32'(0));
        check("rst_r",     32'(bus.rsp_remainder), 32'(0));
        check("rst_id",    32'(bus.rsp_id), 32'(0));
        check("rst_dbz",   32'(bus.rsp_dbz), 32'(0));
        check_stats();
    endtask

    task automatic check_rsp(input string tag, input bit id, input logic [3:0] q,
                             input logic [3:0] r, input bit dbz);
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'(1));
        check({tag, "_id"},    32'(bus.rsp_id), 32'(id));
        check({tag, "_q"},     32'(bus.rsp_quotient), 32'(q));
        check({tag, "_r"},     32'(bus.rsp_remainder), 32'(r));
        check({tag, "_dbz"},   32'(bus.rsp_dbz), 32'(dbz));
    endtask

    // One full transaction: offer, accept, wait for result, optional stall, handshake
    task automatic do_op(input bit v0, input bit v1,
                         input logic [3:0] a0, input logic [3:0] b0,
                         input logic [3:0] a1, input logic [3:0] b1,
                         input int gap, input int stall, input bit pile_on);
        bit         id;
        bit         edbz;
        logic [3:0] a, b, eq, er;
        int         n, exp_lat;

        id = (v0 && v1) ? m_ptr : v1;
        a  = id ? a1 : a0;
        b  = id ? b1 : b0;
        if (b == 4'd0) begin
            eq = 4'hF; er = 4'hF; edbz = 1'b1; exp_lat = 0;
        end else begin
            eq = a / b; er = a % b; edbz = 1'b0; exp_lat = gap + int'(W);
        end

        bus.req0_valid    = v0;
        bus.req0_dividend = a0;
        bus.req0_divisor  = b0;
        bus.req1_valid    = v1;
        bus.req1_dividend = a1;
        bus.req1_divisor  = b1;
        #1;
        check("grant0", 32'(bus.req0_ready), 32'(v0 && !id));
        check("grant1", 32'(bus.req1_ready), 32'(v1 && id));
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        m_ptr = ~id;
        if (b != 4'd0 && gap > 0) ena = 1'b0;

        check("busy_run", 32'(busy), 32'(1));
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            step();
            n++;
            if (n == gap) ena = 1'b1;
        end
        ena = 1'b1;
        check("latency", 32'(n), 32'(exp_lat));
        check_rsp("rsp", id, eq, er, edbz);

        if (pile_on) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < stall; i++) begin
            step();
            check_rsp("hold", id, eq, er, edbz);
            check("hold_rdy0", 32'(bus.req0_ready), 32'(0));
            check("hold_rdy1", 32'(bus.req1_ready), 32'(0));
            check("hold_busy", 32'(busy), 32'(1));
        end
        if (stall > 0) begin
            ena = 1'b0;
            bus.rsp_ready = 1'b1;
            step();
            check("ena_hold_valid", 32'(bus.rsp_valid), 32'(1));
            ena = 1'b1;
        end

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        m_ops++;
        if (edbz) m_dbz++;
        check("post_valid", 32'(bus.rsp_valid), 32'(0));
        check("post_busy",  32'(busy), 32'(0));
        check_stats();
    endtask

    initial begin
        bit         v0, v1;
        logic [3:0] a0, b0, a1, b1;

        ena               = 1'b1;
        rst               = 1'b1;
        bus.req0_valid    = 1'b0;
        bus.req1_valid    = 1'b0;
        bus.req0_dividend = '0;
        bus.req0_divisor  = '0;
        bus.req1_dividend = '0;
        bus.req1_divisor  = '0;
        bus.rsp_ready     = 1'b0;
        reset_dut();

        do_op(1'b1, 1'b0, 4'd13, 4'd3, 4'd0, 4'd0, 0, 0, 1'b0);

        reset_dut();
        do_op(1'b1, 1'b1, 4'd9, 4'd2, 4'd15, 4'd4, 0, 0, 1'b0);
        do_op(1'b1, 1'b1, 4'd9, 4'd2, 4'd15, 4'd4, 0, 0, 1'b0);
        do_op(1'b1, 1'b1, 4'd9, 4'd2, 4'd15, 4'd4, 0, 0, 1'b0);

        reset_dut();
        do_op(1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 4'd0, 0, 0, 1'b0);

        do_op(1'b1, 1'b0, 4'd11, 4'd3, 4'd0, 4'd0, 0, 5, 1'b1);
        do_op(1'b1, 1'b0, 4'd14, 4'd5, 4'd0, 4'd0, 3, 0, 1'b0);

        // Reset in the middle of a calculation discards it
        bus.req0_valid    = 1'b1;
        bus.req0_dividend = 4'd14;
        bus.req0_divisor  = 4'd5;
        step();
        bus.req0_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst   = 1'b0;
        m_ptr = 1'b0;
        m_ops = 0;
        m_dbz = 0;
        check("midrst_valid", 32'(bus.rsp_valid), 32'(0));
        check("midrst_busy",  32'(busy), 32'(0));
        for (int i = 0; i < 6; i++) begin
            step();
            check("midrst_quiet", 32'(bus.rsp_valid), 32'(0));
        end
        do_op(1'b1, 1'b1, 4'd8, 4'd8, 4'd3, 4'd1, 0, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            a0 = 4'($urandom);
            b0 = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            a1 = 4'($urandom);
            b1 = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            do_op(v0, v1, a0, b0, a1, b1, $urandom_range(0, 2), $urandom_range(0, 2),
                  1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
